// File: rtl/nec_prefetch_queue.sv
// Instruction prefetch queue for the NEC V-series core: fetches words ahead of the pre-decoder.
// Define NEC_PREFETCH_BYPASS_EN to forward ack data straight into an empty window.
module nec_prefetch_queue #(
  parameter int QUEUE_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [15:0] flush_ip,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [47:0] window,
  output logic [3:0]  valid_bytes,
  output logic [15:0] ip,
  input  logic        consume,
  input  logic [3:0]  consume_size
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_next;

  logic [7:0]    mem [QUEUE_BYTES];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count, count_next, free_now, free_next;
  logic [15:0]   fetch_ip, fetch_ip_next, ip_next;
  logic          started;
  logic          accept;
  logic          load_addr;
  logic [1:0]    pushed;
  logic [3:0]    consumed;

  // An odd fetch_ip keeps only the odd byte of the returned word.
  assign accept        = (state == REQ) && fetch_ack && !flush;
  assign pushed        = accept ? (fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
  assign consumed      = (consume && consume_size != 4'd0 && consume_size <= valid_bytes)
                         ? consume_size : 4'd0;
  assign count_next    = count + CW'(pushed) - CW'(consumed);
  assign free_now      = CW'(QUEUE_BYTES) - count;
  assign free_next     = CW'(QUEUE_BYTES) - count_next;
  assign fetch_ip_next = fetch_ip + {14'd0, pushed};
  assign ip_next       = ip + {12'd0, consumed};
  assign fetch_req     = (state != IDLE);

  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && started && free_now >= CW'(2)) begin
          state_next = REQ;
          load_addr  = 1'b1;
        end
      end
      REQ: begin
        // A posted request is never withdrawn; a flush must wait out its ack.
        if (flush) begin
          state_next = fetch_ack ? IDLE : DISCARD;
        end else if (fetch_ack) begin
          if (free_next >= CW'(2)) begin
            state_next = REQ;
            load_addr  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (fetch_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      started    <= 1'b0;
      rd         <= '0;
      wr         <= '0;
      count      <= '0;
      fetch_ip   <= '0;
      ip         <= '0;
      fetch_addr <= '0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      if (load_addr) fetch_addr <= {fetch_ip_next[15:1], 1'b0};
      if (flush) begin
        rd       <= '0;
        wr       <= '0;
        count    <= '0;
        fetch_ip <= flush_ip;
        ip       <= flush_ip;
      end else begin
        rd       <= rd + PW'(consumed);
        wr       <= wr + PW'(pushed);
        count    <= count_next;
        fetch_ip <= fetch_ip_next;
        ip       <= ip_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (fetch_ip[0]) begin
        mem[wr] <= fetch_data[15:8];
      end else begin
        mem[wr]          <= fetch_data[7:0];
        mem[wr + PW'(1)] <= fetch_data[15:8];
      end
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < 6; i++) begin
      if (CW'(i) < count) window[8*i +: 8] = mem[rd + PW'(i)];
    end
`ifdef NEC_PREFETCH_BYPASS_EN
    if (count == '0 && accept) begin
      window[7:0] = fetch_ip[0] ? fetch_data[15:8] : fetch_data[7:0];
      if (!fetch_ip[0]) window[15:8] = fetch_data[15:8];
    end
`endif
  end

  always_comb begin
    valid_bytes = (count >= CW'(6)) ? 4'd6 : 4'(count);
`ifdef NEC_PREFETCH_BYPASS_EN
    if (count == '0 && accept) valid_bytes = {2'b00, pushed};
`endif
  end
endmodule

// File: doc/nec_prefetch_queue.md
# nec_prefetch_queue

Instruction prefetch queue for the NEC V-series core, sitting directly upstream of the pre-decoder. It issues word fetches on the bus interface ahead of execution, buffers the returned bytes, and presents a 6-byte window starting at the current instruction pointer. The pre-decoder consumes a whole instruction per pulse, sized by its `pre_size`. Branches flush the queue.

## Interface
- `QUEUE_BYTES`, 8: storage depth in bytes; power of two, ≥ 8.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard queue contents and restart fetching at `flush_ip`.
- `flush_ip`  in  16  new PS offset, sampled when `flush`=1.
- `fetch_req`  out  1  bus word-fetch request; held until `fetch_ack`.
- `fetch_addr`  out  16  word-aligned fetch offset, `{fetch_ip[15:1],1'b0}`.
- `fetch_ack`  in  1  bus returns data this cycle.
- `fetch_data`  in  16  fetched word; [7:0] is the even byte, [15:8] the odd byte.
- `window`  out  48  next 6 queued bytes; byte0 in [7:0] is at `ip`.
- `valid_bytes`  out  4  count of valid window bytes, 0..6.
- `ip`  out  16  offset of window byte0.
- `consume`  in  1  pre-decoder retires `consume_size` bytes.
- `consume_size`  in  4  bytes to retire, 1..6.

## Operation
- Internal state:
  - circular byte store, read pointer `rd`, `count`;
  - `fetch_ip`, the next offset to fetch;
  - FSM {IDLE, REQ, DISCARD}.
- Window bytes at positions ≥ `valid_bytes` read as 0x00.
- `valid_bytes` = min(count, 6).
- IDLE → REQ when `QUEUE_BYTES - count` ≥ 2 and `flush`=0. Entering REQ latches `fetch_req`=1.
- REQ with `fetch_ack`=1:
  - even `fetch_ip`: push both bytes; `fetch_ip` += 2.
  - odd `fetch_ip`: push `fetch_data[15:8]` only; `fetch_ip` += 1.
  - Then stay in REQ if free space after this cycle's push and consume is ≥ 2, else go to IDLE.
- `fetch_ip` and `ip` wrap modulo 2^16 (FFFF → 0000) with no segment change.
- Consume:
  - Legal only when `consume_size` ≤ `valid_bytes`; otherwise ignored, with no state change.
  - A legal consume advances `rd` and `ip` by `consume_size` and decrements `count`.
- A push and a consume in the same cycle both apply: count' = count + pushed − consumed.
- `flush`=1 has priority over consume and push:
  - count, rd and the write pointer are cleared; `ip` and `fetch_ip` are set to `flush_ip`.
  - From REQ with `fetch_ack`=0: go to DISCARD. `fetch_req` stays high, because a request is never withdrawn.
  - From REQ with `fetch_ack`=1: the data is dropped; go to IDLE.
  - From DISCARD: stay in DISCARD.
- DISCARD: on `fetch_ack`, drop the data and go to IDLE. `fetch_addr` holds the original address until the ack.

## Timing
- Reset values:
  - `fetch_req`=0, `fetch_addr`=0x0000;
  - `ip`=0x0000, `fetch_ip`=0x0000;
  - `valid_bytes`=0, `window`=0, FSM=IDLE.
- First `fetch_req` asserts on the second rising edge after `reset_n` deasserts: one edge sees IDLE, the next enters REQ.
- `fetch_req` and `fetch_addr` are registered and stable while waiting for the ack.
- Bytes pushed on the ack edge appear in `window` the next cycle (1-cycle latency).
- After a consume, the updated `window`, `ip` and `valid_bytes` are visible the next cycle.
- After `flush`, `valid_bytes`=0 the next cycle, and a new request asserts one cycle later if not in DISCARD.
- Back-to-back fetches: `fetch_req` may stay high across consecutive acks, giving one word per ack cycle.
- Asserting `reset_n`=0 mid-request forces the reset values immediately. The bus owner must abandon the outstanding cycle.

## Configuration
- `NEC_PREFETCH_BYPASS_EN` defined: when `count`=0 and not flushing, an accepted byte in an ack cycle appears combinationally in `window` byte0 (and byte1 for even fetches), with `valid_bytes` raised the same cycle. A same-cycle consume of bypassed bytes is legal.
- Undefined: strictly 1-cycle latency from ack to window, with no combinational path from `fetch_*` to decoder outputs.

## Test plan
- Reset, then ack every request with 0x1100, 0x3322, 0x5544, 0x7766 → `fetch_addr` 0000, 0002, 0004, 0006; `window` bytes 00,11,22,33,44,55; `valid_bytes`=6; `fetch_req` drops once count=8.
- `flush_ip`=0x0101 with data 0xAB00 → `fetch_addr`=0x0100, one byte 0xAB pushed, next `fetch_addr`=0x0102, `ip`=0x0101.
- `flush` while REQ is pending for 0x0004, then ack 0xDEAD → data dropped, `valid_bytes` stays 0, next request at the `flush_ip` word.
- Queue holds 5 bytes; `consume_size`=3 in the same cycle as an even ack → `valid_bytes`=4, `ip`+=3.
- `consume_size`=5 with `valid_bytes`=3 → ignored; `ip` and `valid_bytes` unchanged.
- `flush_ip`=0xFFFE with acks of 0x2211 and 0x4433 → second `fetch_addr`=0x0000, window 11,22,33,44; `ip` wraps 0xFFFE→0x0000 after a 2-byte consume.
